// File: rtl/timer_bank_pkg.sv
// rtl/timer_bank_pkg.sv - shared channel state encoding and default timing constants
package timer_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } ch_state_t;

  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_TICK_DIV = DEF_CLK_FREQ;
  localparam int DEF_WARN_TH  = 3;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one countdown channel: prescaler, counter and state machine
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   i_start     : load i_init_val and run (pulse)
//   i_en        : count enable level; low pauses
//   i_stop      : abort to IDLE (pulse)
//   i_reload    : auto-reload mode, sampled at expiry
//   i_init_val  : start value
//   o_curr_sec  : remaining ticks
//   o_timeout   : one-cycle expiry pulse
//   o_running   : RUN or PAUSE
//   o_warn      : running with 0 < remaining <= WARN_TH
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int SEC_W    = 8,
  parameter int WARN_TH  = DEF_WARN_TH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_en,
  input  logic             i_stop,
  input  logic             i_reload,
  input  logic [SEC_W-1:0] i_init_val,
  output logic [SEC_W-1:0] o_curr_sec,
  output logic             o_timeout,
  output logic             o_running,
  output logic             o_warn
);

  localparam int             PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0] ONE   = SEC_W'(1);
  localparam logic [SEC_W-1:0] TH    = SEC_W'(WARN_TH);

  ch_state_t        r_state;
  logic [PW-1:0]    r_pre;
  logic [SEC_W-1:0] r_cnt;
  logic [SEC_W-1:0] r_reload_val;
  logic             r_timeout;
  // A zero-valued start parks in DONE and fires its pulse one edge later.
  logic             r_zero_pend;

  logic w_tick;
  logic w_running;

  assign w_tick    = (r_pre == PRE_MAX);
  assign w_running = (r_state == ST_RUN) || (r_state == ST_PAUSE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pre        <= '0;
      r_cnt        <= '0;
      r_reload_val <= '0;
      r_timeout    <= 1'b0;
      r_zero_pend  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (i_stop) begin
        r_state     <= ST_IDLE;
        r_pre       <= '0;
        r_zero_pend <= 1'b0;
      end else if (i_start) begin
        r_reload_val <= i_init_val;
        r_cnt        <= i_init_val;
        r_pre        <= '0;
        if (i_init_val == '0) begin
          r_state     <= ST_DONE;
          r_zero_pend <= 1'b1;
        end else begin
          r_state     <= ST_RUN;
          r_zero_pend <= 1'b0;
        end
      end else begin
        case (r_state)
          ST_RUN, ST_PAUSE: begin
            if (!i_en) begin
              r_state <= ST_PAUSE;
            end else begin
              // The resume cycle itself counts, so every enabled cycle advances the prescaler.
              r_state <= ST_RUN;
              if (w_tick) begin
                r_pre <= '0;
                if (r_cnt > ONE) begin
                  r_cnt <= r_cnt - ONE;
                end else if (r_cnt == ONE) begin
                  r_timeout <= 1'b1;
                  if (i_reload) begin
                    r_cnt <= r_reload_val;
                  end else begin
                    r_cnt   <= '0;
                    r_state <= ST_DONE;
                  end
                end
              end else begin
                r_pre <= r_pre + PW'(1);
              end
            end
          end
          ST_DONE: begin
            if (r_zero_pend) begin
              r_timeout   <= 1'b1;
              r_zero_pend <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_curr_sec = r_cnt;
  assign o_timeout  = r_timeout;
  assign o_running  = w_running;
  assign o_warn     = w_running && (r_cnt != '0) && (r_cnt <= TH);

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of N_CH independent countdown timer channels
//
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   i_start        : per-channel load-and-run pulse
//   i_en           : per-channel count enable
//   i_stop         : per-channel abort pulse
//   i_reload       : per-channel auto-reload mode
//   i_init_val     : per-channel start value, SEC_W bits each
//   o_curr_sec     : per-channel remaining ticks, packed like i_init_val
//   o_timeout      : per-channel expiry pulse
//   o_running      : per-channel RUN or PAUSE
//   o_warn         : per-channel near-expiry flag
//   o_any_timeout  : OR of o_timeout
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int TICK_DIV = CLK_FREQ,
  parameter int N_CH     = 4,
  parameter int SEC_W    = 8,
  parameter int WARN_TH  = DEF_WARN_TH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       i_start,
  input  logic [N_CH-1:0]       i_en,
  input  logic [N_CH-1:0]       i_stop,
  input  logic [N_CH-1:0]       i_reload,
  input  logic [N_CH*SEC_W-1:0] i_init_val,
  output logic [N_CH*SEC_W-1:0] o_curr_sec,
  output logic [N_CH-1:0]       o_timeout,
  output logic [N_CH-1:0]       o_running,
  output logic [N_CH-1:0]       o_warn,
  output logic                  o_any_timeout
);

  logic [N_CH-1:0] w_timeout;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    timer_channel #(
      .TICK_DIV (TICK_DIV),
      .SEC_W    (SEC_W),
      .WARN_TH  (WARN_TH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (i_start[k]),
      .i_en       (i_en[k]),
      .i_stop     (i_stop[k]),
      .i_reload   (i_reload[k]),
      .i_init_val (i_init_val[k*SEC_W +: SEC_W]),
      .o_curr_sec (o_curr_sec[k*SEC_W +: SEC_W]),
      .o_timeout  (w_timeout[k]),
      .o_running  (o_running[k]),
      .o_warn     (o_warn[k])
    );
  end

  assign o_timeout     = w_timeout;
  // Each bit is a registered pulse, so the OR lands in the same cycle.
  assign o_any_timeout = |w_timeout;

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - directed self-checking bench for timer_bank
module tb_timer_bank;

  localparam int N_CH  = 4;
  localparam int SEC_W = 8;

  logic                  clk;
  logic                  rst_n;
  logic [N_CH-1:0]       i_start;
  logic [N_CH-1:0]       i_en;
  logic [N_CH-1:0]       i_stop;
  logic [N_CH-1:0]       i_reload;
  logic [N_CH*SEC_W-1:0] i_init_val;
  logic [N_CH*SEC_W-1:0] o_curr_sec;
  logic [N_CH-1:0]       o_timeout;
  logic [N_CH-1:0]       o_running;
  logic [N_CH-1:0]       o_warn;
  logic                  o_any_timeout;

  int n_checks = 0;
  int n_errors = 0;

  timer_bank #(
    .CLK_FREQ (100),
    .TICK_DIV (4),
    .N_CH     (N_CH),
    .SEC_W    (SEC_W),
    .WARN_TH  (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_en          (i_en),
    .i_stop        (i_stop),
    .i_reload      (i_reload),
    .i_init_val    (i_init_val),
    .o_curr_sec    (o_curr_sec),
    .o_timeout     (o_timeout),
    .o_running     (o_running),
    .o_warn        (o_warn),
    .o_any_timeout (o_any_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SEC_W-1:0] sec(input int k);
    return o_curr_sec[k*SEC_W +: SEC_W];
  endfunction

  task automatic set_init(input int k, input logic [SEC_W-1:0] v);
    i_init_val[k*SEC_W +: SEC_W] = v;
  endtask

  // Pulse i_start on the given mask; on return we sit just after the start edge.
  task automatic start(input logic [N_CH-1:0] m);
    i_start = m;
    step();
    i_start = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    i_start    = '0;
    i_en       = '1;
    i_stop     = '0;
    i_reload   = '0;
    i_init_val = '0;
    step(); step(); step();
    chk("rst curr_sec", o_curr_sec, 0);
    chk("rst timeout", {28'd0, o_timeout}, 0);
    chk("rst running", {28'd0, o_running}, 0);
    chk("rst warn", {28'd0, o_warn}, 0);
    chk("rst any", {31'd0, o_any_timeout}, 0);
    rst_n = 1'b1;
    step();

    // ch0: init 3, counts 3,2,1,0 at 4/8/12, single pulse at 12
    set_init(0, 8'd3);
    start(4'b0001);
    chk("t1 c0 cnt", {24'd0, sec(0)}, 3);
    chk("t1 c0 warn", {31'd0, o_warn[0]}, 1);
    for (int c = 1; c <= 14; c++) begin
      step();
      chk($sformatf("t1 c%0d cnt", c), {24'd0, sec(0)},
          (c < 4) ? 3 : (c < 8) ? 2 : (c < 12) ? 1 : 0);
      chk($sformatf("t1 c%0d tmo", c), {31'd0, o_timeout[0]}, (c == 12) ? 1 : 0);
      chk($sformatf("t1 c%0d any", c), {31'd0, o_any_timeout}, (c == 12) ? 1 : 0);
      chk($sformatf("t1 c%0d run", c), {31'd0, o_running[0]}, (c < 12) ? 1 : 0);
    end

    // ch1: init 5 with en low for cycles 6..15 -> expiry at 30
    set_init(1, 8'd5);
    start(4'b0010);
    for (int c = 1; c <= 31; c++) begin
      i_en[1] = !(c >= 6 && c <= 15);
      step();
      chk($sformatf("t2 c%0d tmo", c), {31'd0, o_timeout[1]}, (c == 30) ? 1 : 0);
      chk($sformatf("t2 c%0d run", c), {31'd0, o_running[1]}, (c < 30) ? 1 : 0);
      if (c == 10) chk("t2 paused cnt", {24'd0, sec(1)}, 4);
    end
    i_en = '1;

    // ch2: auto-reload init 2 -> pulses at 8,16,24, warn held high
    i_reload[2] = 1'b1;
    set_init(2, 8'd2);
    start(4'b0100);
    for (int c = 1; c <= 26; c++) begin
      step();
      chk($sformatf("t3 c%0d tmo", c), {31'd0, o_timeout[2]},
          (c == 8 || c == 16 || c == 24) ? 1 : 0);
      chk($sformatf("t3 c%0d warn", c), {31'd0, o_warn[2]}, 1);
    end
    i_stop = 4'b0100;
    step();
    i_stop = '0;
    i_reload[2] = 1'b0;
    chk("t3 stop run", {31'd0, o_running[2]}, 0);
    chk("t3 stop warn", {31'd0, o_warn[2]}, 0);
    step();
    chk("t3 stop no tmo", {31'd0, o_timeout[2]}, 0);

    // ch3: zero init pulses one cycle later without running
    set_init(3, 8'd0);
    start(4'b1000);
    chk("t4 zero run", {31'd0, o_running[3]}, 0);
    chk("t4 zero tmo0", {31'd0, o_timeout[3]}, 0);
    step();
    chk("t4 zero tmo1", {31'd0, o_timeout[3]}, 1);
    step();
    chk("t4 zero tmo2", {31'd0, o_timeout[3]}, 0);

    // ch3: restart init 9, then init 4 at cycle 6 -> expiry 16 after second start
    set_init(3, 8'd9);
    start(4'b1000);
    for (int c = 1; c <= 5; c++) step();
    set_init(3, 8'd4);
    start(4'b1000);
    chk("t4 restart cnt", {24'd0, sec(3)}, 4);
    for (int c = 1; c <= 17; c++) begin
      step();
      chk($sformatf("t4 c%0d tmo", c), {31'd0, o_timeout[3]}, (c == 16) ? 1 : 0);
    end

    // reset at cycle 10 of ch0 init 3, stop ch1 mid-count at cycle 5
    set_init(0, 8'd3);
    set_init(1, 8'd5);
    set_init(2, 8'd7);
    start(4'b0011);
    for (int c = 1; c <= 14; c++) begin
      i_stop[1]  = (c == 5);
      rst_n      = !(c >= 10 && c <= 12);
      i_start[2] = (c == 10);
      step();
      chk($sformatf("t5 c%0d tmo", c), {28'd0, o_timeout}, 0);
      chk($sformatf("t5 c%0d any", c), {31'd0, o_any_timeout}, 0);
      if (c == 5) begin
        chk("t5 stop run", {31'd0, o_running[1]}, 0);
        chk("t5 stop keep cnt", {24'd0, sec(1)}, 4);
      end
      if (c >= 10) begin
        chk($sformatf("t5 c%0d curr", c), o_curr_sec, 0);
        chk($sformatf("t5 c%0d run", c), {28'd0, o_running}, 0);
        chk($sformatf("t5 c%0d warn", c), {28'd0, o_warn}, 0);
      end
    end
    i_start = '0;
    i_stop  = '0;
    rst_n   = 1'b1;
    set_init(1, 8'd2);
    start(4'b0010);
    for (int c = 1; c <= 9; c++) begin
      step();
      chk($sformatf("t5r c%0d tmo", c), {31'd0, o_timeout[1]}, (c == 8) ? 1 : 0);
    end

    // simultaneous expiry of ch0 and ch2
    set_init(0, 8'd2);
    set_init(2, 8'd2);
    start(4'b0101);
    for (int c = 1; c <= 9; c++) begin
      step();
      chk($sformatf("t6 c%0d tmo", c), {28'd0, o_timeout}, (c == 8) ? 4'b0101 : 4'b0000);
      chk($sformatf("t6 c%0d any", c), {31'd0, o_any_timeout}, (c == 8) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
